// File: rtl/trace_pkg.sv
// Shared definitions for the retire-event tracer: FSM encoding, record flag
// positions and the record field layout used by both RTL and bench decoders.
package trace_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_FROZEN  = 2'd3
    } trace_state_t;

    localparam int FLAG_W   = 3;
    localparam int FLAG_WB  = 2;
    localparam int FLAG_MR  = 1;
    localparam int FLAG_MW  = 0;
    localparam int WB_REG_W = 5;

    // Record: {cycle, pc, flags, wb_reg, mem_addr, wb_data, mem_data}
    function automatic int rec_width(input int cyc_w, input int pc_w,
                                     input int addr_w, input int data_w);
        return cyc_w + pc_w + FLAG_W + WB_REG_W + addr_w + 2 * data_w;
    endfunction

    function automatic int off_mem_data();
        return 0;
    endfunction

    function automatic int off_wb_data(input int data_w);
        return data_w;
    endfunction

    function automatic int off_mem_addr(input int data_w);
        return 2 * data_w;
    endfunction

    function automatic int off_wb_reg(input int addr_w, input int data_w);
        return 2 * data_w + addr_w;
    endfunction

    function automatic int off_flags(input int addr_w, input int data_w);
        return off_wb_reg(addr_w, data_w) + WB_REG_W;
    endfunction

    function automatic int off_pc(input int addr_w, input int data_w);
        return off_flags(addr_w, data_w) + FLAG_W;
    endfunction

    function automatic int off_cyc(input int pc_w, input int addr_w, input int data_w);
        return off_pc(addr_w, data_w) + pc_w;
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO with a fall-through head read straight from the storage
// registers. Pointers wrap naturally (DEPTH is a power of two); full and
// empty come from the occupancy count.
module trace_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           push,
    input  logic [WIDTH-1:0]               data_in,
    input  logic                           pop,
    output logic [WIDTH-1:0]               data_out,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(DEPTH+1)-1:0]     level
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty    = (level == '0);
    assign full     = (level == LVL_W'(DEPTH));
    assign do_pop   = pop && !empty;
    // A push into a full FIFO is only legal when the head leaves this cycle.
    assign do_push  = push && (!full || do_pop);
    assign data_out = empty ? '0 : mem[rd_ptr];

    // Storage write; contents need no reset since level gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= data_in;
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      level <= level + 1'b1;
            else if (!do_push && do_pop) level <= level - 1'b1;
        end
    end

endmodule

// File: rtl/trace_capture_unit.sv
// Retire-event tracer: packs writeback / data-memory activity into
// cycle-stamped records and queues them behind a valid/ready drain port.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | not capturing; waits for arm
// ARMED   | waiting for trigger (pc==trig_pc, or immediately if !trig_en)
// CAPTURE | every event cycle produces a record
// FROZEN  | capture stopped; FIFO still drains; arm re-enters ARMED
module trace_capture_unit
    import trace_pkg::*;
#(
    parameter int DATA_W        = 32,
    parameter int PC_W          = 32,
    parameter int ADDR_W        = 10,
    parameter int CYC_W         = 16,
    parameter int DEPTH         = 16,
    parameter int CAPTURE_LIMIT = 0
) (
    input  logic                                              clk,
    input  logic                                              rst_n,
    input  logic                                              arm,
    input  logic                                              trig_en,
    input  logic [PC_W-1:0]                                   trig_pc,
    input  logic                                              finish,
    input  logic [PC_W-1:0]                                   pc,
    input  logic                                              wb_en,
    input  logic [4:0]                                        wb_reg,
    input  logic [DATA_W-1:0]                                 wb_data,
    input  logic                                              mem_rd,
    input  logic [DATA_W-1:0]                                 mem_rd_data,
    input  logic                                              mem_wr,
    input  logic [ADDR_W-1:0]                                 mem_addr,
    input  logic [DATA_W-1:0]                                 mem_wr_data,
    output logic                                              out_valid,
    input  logic                                              out_ready,
    output logic [rec_width(CYC_W, PC_W, ADDR_W, DATA_W)-1:0] out_record,
    output logic [1:0]                                        state,
    output logic [$clog2(DEPTH+1)-1:0]                        level,
    output logic [15:0]                                       drop_count
);
    localparam int          REC_W    = rec_width(CYC_W, PC_W, ADDR_W, DATA_W);
    localparam logic [31:0] ACC_LAST = 32'(CAPTURE_LIMIT - 1);

    trace_state_t      st;
    logic [CYC_W-1:0]  cyc;
    logic [31:0]       acc_count;
    logic              wb_eff;
    logic              evt;
    logic [DATA_W-1:0] mem_data;
    logic [REC_W-1:0]  rec;
    logic              fin_req;
    logic              trig_hit;
    logic              capture_now;
    logic              push_req;
    logic              push;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic              limit_hit;

    assign state    = st;
    // Writes to $0 are architectural no-ops and never logged.
    assign wb_eff   = wb_en && (wb_reg != 5'd0);
    assign evt      = wb_eff || mem_rd || mem_wr;
    assign mem_data = mem_wr ? mem_wr_data : (mem_rd ? mem_rd_data : '0);
    assign rec      = {cyc, pc, wb_eff, mem_rd, mem_wr, wb_reg, mem_addr, wb_data, mem_data};

    assign fin_req     = finish && (st != ST_IDLE);
    assign trig_hit    = (st == ST_ARMED) && (!trig_en || (pc == trig_pc));
    // Trigger cycle records its own event unless a freeze wins that cycle;
    // the finish cycle itself still records while already capturing.
    assign capture_now = (st == ST_CAPTURE) || (trig_hit && !fin_req);
    assign push_req    = capture_now && evt;
    assign out_valid   = !fifo_empty;
    assign pop         = out_valid && out_ready;
    assign push        = push_req && (!fifo_full || pop);
    assign limit_hit   = (CAPTURE_LIMIT != 0) && push && (acc_count == ACC_LAST);

    trace_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .data_in  (rec),
        .pop      (pop),
        .data_out (out_record),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .level    (level)
    );

    // Capture control FSM and accepted-record count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st        <= ST_IDLE;
            acc_count <= '0;
        end else begin
            if (push) acc_count <= acc_count + 32'd1;
            if (fin_req) begin
                st <= ST_FROZEN;
            end else begin
                case (st)
                    ST_IDLE, ST_FROZEN: begin
                        if (arm) begin
                            st        <= ST_ARMED;
                            acc_count <= '0;
                        end
                    end
                    ST_ARMED:   if (trig_hit) st <= limit_hit ? ST_FROZEN : ST_CAPTURE;
                    ST_CAPTURE: if (limit_hit) st <= ST_FROZEN;
                    default:    st <= ST_IDLE;
                endcase
            end
        end
    end

    // Free-running cycle stamp and saturating drop counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc        <= '0;
            drop_count <= '0;
        end else begin
            cyc <= cyc + 1'b1;
            if (push_req && !push && (drop_count != 16'hFFFF))
                drop_count <= drop_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_trace_capture_unit.sv
// Scoreboard bench for trace_capture_unit: expected records are queued as
// events are driven and compared whenever the head is handshaken out.
module tb_trace_capture_unit;
    import trace_pkg::*;

    localparam int DATA_W = 32;
    localparam int PC_W   = 32;
    localparam int ADDR_W = 10;
    localparam int CYC_W  = 16;
    localparam int DEPTH  = 16;
    localparam int REC_W  = rec_width(CYC_W, PC_W, ADDR_W, DATA_W);
    localparam int LVL_W  = $clog2(DEPTH + 1);

    localparam int OFF_FLAGS = off_flags(ADDR_W, DATA_W);
    localparam int OFF_PC    = off_pc(ADDR_W, DATA_W);
    localparam int OFF_WBREG = off_wb_reg(ADDR_W, DATA_W);
    localparam int OFF_ADDR  = off_mem_addr(DATA_W);
    localparam int OFF_WBD   = off_wb_data(DATA_W);
    localparam int OFF_MD    = off_mem_data();

    logic              clk;
    logic              rst_n;
    logic              arm, arm2, trig_en, finish, finish2;
    logic [PC_W-1:0]   trig_pc, pc;
    logic              wb_en, mem_rd, mem_wr;
    logic [4:0]        wb_reg;
    logic [DATA_W-1:0] wb_data, mem_rd_data, mem_wr_data;
    logic [ADDR_W-1:0] mem_addr;
    logic              out_ready, out_ready2;
    logic              out_valid, out_valid2;
    logic [REC_W-1:0]  out_record, out_record2;
    logic [1:0]        state, state2;
    logic [LVL_W-1:0]  level, level2;
    logic [15:0]       drop_count, drop_count2;

    trace_capture_unit #(
        .DATA_W(DATA_W), .PC_W(PC_W), .ADDR_W(ADDR_W), .CYC_W(CYC_W),
        .DEPTH(DEPTH), .CAPTURE_LIMIT(0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .arm(arm), .trig_en(trig_en), .trig_pc(trig_pc),
        .finish(finish), .pc(pc), .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data),
        .mem_rd(mem_rd), .mem_rd_data(mem_rd_data), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wr_data(mem_wr_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_record(out_record), .state(state), .level(level), .drop_count(drop_count)
    );

    trace_capture_unit #(
        .DATA_W(DATA_W), .PC_W(PC_W), .ADDR_W(ADDR_W), .CYC_W(CYC_W),
        .DEPTH(DEPTH), .CAPTURE_LIMIT(3)
    ) dut_lim (
        .clk(clk), .rst_n(rst_n), .arm(arm2), .trig_en(trig_en), .trig_pc(trig_pc),
        .finish(finish2), .pc(pc), .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data),
        .mem_rd(mem_rd), .mem_rd_data(mem_rd_data), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wr_data(mem_wr_data), .out_valid(out_valid2), .out_ready(out_ready2),
        .out_record(out_record2), .state(state2), .level(level2), .drop_count(drop_count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int               n_vec  = 0;
    int               n_miss = 0;
    logic [REC_W-1:0] exp_q[$];
    int               m_level;
    int               m_drop;
    trace_state_t     m_state;
    logic [CYC_W-1:0] m_cyc;
    logic [REC_W-1:0] lim_first;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
        n_vec++;
        if (obs !== expv) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [REC_W-1:0] mk_rec();
        logic              wb;
        logic [DATA_W-1:0] md;
        wb = wb_en && (wb_reg != 5'd0);
        md = mem_wr ? mem_wr_data : (mem_rd ? mem_rd_data : '0);
        return {m_cyc, pc, wb, mem_rd, mem_wr, wb_reg, mem_addr, wb_data, md};
    endfunction

    task automatic clr_evt();
        arm = 0; arm2 = 0; finish = 0; finish2 = 0;
        wb_en = 0; mem_rd = 0; mem_wr = 0;
    endtask

    // Apply current inputs for one cycle, updating the reference model.
    task automatic tick();
        bit pop, evt, fin, trig, cap;
        logic [REC_W-1:0] r;
        pop = (m_level > 0) && out_ready;
        if (pop) begin
            chk("head_valid", 256'(out_valid), 256'(1));
            if (exp_q.size() > 0) begin
                r = exp_q.pop_front();
                chk("head_record", 256'(out_record), 256'(r));
            end
        end
        evt  = (wb_en && wb_reg != 5'd0) || mem_rd || mem_wr;
        fin  = finish && (m_state != ST_IDLE);
        trig = (m_state == ST_ARMED) && (!trig_en || pc == trig_pc);
        cap  = (m_state == ST_CAPTURE) || (trig && !fin);
        if (cap && evt) begin
            if (m_level < DEPTH || pop) begin
                exp_q.push_back(mk_rec());
                m_level++;
            end else if (m_drop < 65535) begin
                m_drop++;
            end
        end
        if (pop) m_level--;
        if (fin) m_state = ST_FROZEN;
        else if ((m_state == ST_IDLE || m_state == ST_FROZEN) && arm) m_state = ST_ARMED;
        else if (trig) m_state = ST_CAPTURE;
        @(posedge clk);
        @(negedge clk);
        m_cyc++;
    endtask

    task automatic do_reset();
        rst_n = 0;
        #1;
        chk("rst_level", 256'(level), 256'(0));
        chk("rst_valid", 256'(out_valid), 256'(0));
        chk("rst_state", 256'(state), 256'(0));
        chk("rst_record", 256'(out_record), 256'(0));
        chk("rst_drop", 256'(drop_count), 256'(0));
        @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        exp_q.delete();
        m_level = 0;
        m_drop  = 0;
        m_state = ST_IDLE;
        m_cyc   = '0;
    endtask

    initial begin
        clr_evt();
        trig_en = 0; trig_pc = '0; pc = '0; wb_reg = '0; wb_data = '0;
        mem_rd_data = '0; mem_wr_data = '0; mem_addr = '0;
        out_ready = 1; out_ready2 = 0;
        do_reset();

        // Immediate capture after arm; single writeback event.
        arm = 1; tick(); arm = 0;
        pc = 32'h100; wb_en = 1; wb_reg = 5'd8; wb_data = 32'd5;
        tick(); clr_evt();
        chk("t1_state", 256'(state), 256'(2));
        chk("t1_valid", 256'(out_valid), 256'(1));
        chk("t1_flags", 256'(out_record[OFF_FLAGS +: 3]), 256'(3'b100));
        chk("t1_wbreg", 256'(out_record[OFF_WBREG +: 5]), 256'(8));
        chk("t1_wbdata", 256'(out_record[OFF_WBD +: DATA_W]), 256'(5));
        tick();
        finish = 1; tick(); clr_evt();
        chk("t1_frozen", 256'(state), 256'(3));

        // PC trigger: only the matching cycle onward is recorded.
        trig_en = 1; trig_pc = 32'h20;
        arm = 1; tick(); arm = 0;
        for (int i = 0; i < 3; i++) begin
            pc = 32'h18 + 32'(4 * i);
            wb_en = 1; wb_reg = 5'd3; wb_data = pc;
            tick();
        end
        clr_evt();
        chk("t2_state", 256'(state), 256'(2));
        chk("t2_level", 256'(level), 256'(1));
        chk("t2_pc", 256'(out_record[OFF_PC +: PC_W]), 256'(32'h20));
        tick();
        finish = 1; tick(); clr_evt();

        // Overflow: 20 events into 16 entries with no draining.
        trig_en = 0; out_ready = 0;
        arm = 1; tick(); arm = 0;
        for (int i = 0; i < 20; i++) begin
            pc = 32'h200 + 32'(4 * i);
            mem_wr = 1; mem_addr = ADDR_W'(i); mem_wr_data = DATA_W'(i * 3);
            tick();
        end
        chk("t3_level", 256'(level), 256'(16));
        chk("t3_drop", 256'(drop_count), 256'(4));
        // Push while full is accepted when the head pops the same cycle.
        out_ready = 1; pc = 32'h300; mem_addr = 10'h3FF; mem_wr_data = 32'hDEAD;
        tick(); clr_evt();
        chk("t4_level", 256'(level), 256'(16));
        chk("t4_drop", 256'(drop_count), 256'(4));
        for (int i = 0; i < 17; i++) tick();
        chk("t4_empty", 256'(level), 256'(0));
        chk("t4_valid", 256'(out_valid), 256'(0));

        // $0 writeback suppressed; memory data selection.
        pc = 32'h400; wb_en = 1; wb_reg = 5'd0; wb_data = 32'h77;
        mem_wr = 1; mem_addr = 10'd4; mem_wr_data = 32'hAB;
        tick(); clr_evt();
        chk("t6_flags", 256'(out_record[OFF_FLAGS +: 3]), 256'(3'b001));
        chk("t6_addr", 256'(out_record[OFF_ADDR +: ADDR_W]), 256'(4));
        chk("t6_mdata", 256'(out_record[OFF_MD +: DATA_W]), 256'(32'hAB));
        mem_rd = 1; mem_wr = 1; mem_rd_data = 32'h22; mem_wr_data = 32'h11;
        tick(); clr_evt();
        chk("t6_both_flags", 256'(out_record[OFF_FLAGS +: 3]), 256'(3'b011));
        chk("t6_both_data", 256'(out_record[OFF_MD +: DATA_W]), 256'(32'h11));
        mem_rd = 1; mem_rd_data = 32'h5A5A;
        tick(); clr_evt();
        tick();

        // Reset in the middle of capture discards queued records.
        out_ready = 0; wb_en = 1; wb_reg = 5'd9; wb_data = 32'h99;
        tick(); tick(); clr_evt();
        chk("t7_level", 256'(level), 256'(2));
        do_reset();

        // Capture limit of 3 on the second instance.
        out_ready = 1; trig_en = 0;
        arm2 = 1; tick(); arm2 = 0;
        for (int i = 0; i < 5; i++) begin
            pc = 32'h500 + 32'(4 * i);
            wb_en = 1; wb_reg = 5'(10 + i); wb_data = DATA_W'(i);
            if (i == 0) lim_first = mk_rec();
            tick();
        end
        clr_evt();
        chk("t5_state", 256'(state2), 256'(3));
        chk("t5_level", 256'(level2), 256'(3));
        chk("t5_drop", 256'(drop_count2), 256'(0));
        chk("t5_valid", 256'(out_valid2), 256'(1));
        chk("t5_head", 256'(out_record2), 256'(lim_first));
        chk("t5_main_idle", 256'(level), 256'(0));
        finish2 = 1; arm2 = 1; tick(); clr_evt();
        chk("t5_fin_arm", 256'(state2), 256'(3));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
